// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - byte-stream boot loader that fills the instruction SRAM while holding the CPU.
// Optional LOADER_CHKSUM_EN adds a modulo-256 image checksum trailer and the err_chk flag.
module inst_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              inst_sram_wr,
    output logic [ADDR_W-1:0] inst_sram_addr,
    output logic [DATA_W-1:0] inst_sram_data,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
`ifdef LOADER_CHKSUM_EN
    output logic              err_chk,
`endif
    output logic              err_ovf
);

`ifdef LOADER_CHKSUM_EN
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CHK, ST_DONE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;
`endif

    state_t              r_state;
    logic                r_ready;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_hold;
    logic                r_done;
    logic                r_ovf;
    logic [ADDR_W:0]     r_word_idx;
    logic [1:0]          r_byte_idx;
    logic [23:0]         r_asm;
`ifdef LOADER_CHKSUM_EN
    logic [7:0]          r_sum;
    logic                r_err_chk;
`endif

    logic                w_acc;
    logic                w_full;
    logic                w_end_word;
    logic [DATA_W-1:0]   w_word;

    assign w_acc      = s_valid & r_ready;
    // Index bit ADDR_W set means every SRAM word has been written; further bytes are dropped.
    assign w_full     = r_word_idx[ADDR_W];
    assign w_end_word = (r_byte_idx == 2'd3) | s_last;
    assign w_word     = DATA_W'({8'h00, r_asm}) | (DATA_W'(s_data) << {r_byte_idx, 3'b000});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b0;
            r_wr       <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
`ifdef LOADER_CHKSUM_EN
            r_sum      <= '0;
            r_err_chk  <= 1'b0;
`endif
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_LOAD;
                        r_ready    <= 1'b1;
                        r_hold     <= 1'b1;
                        r_done     <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_asm      <= '0;
`ifdef LOADER_CHKSUM_EN
                        r_sum      <= '0;
                        r_err_chk  <= 1'b0;
`endif
                    end else if (r_state == ST_DONE) begin
                        r_hold <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_acc) begin
`ifdef LOADER_CHKSUM_EN
                        r_sum <= r_sum + s_data;
`endif
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else if (w_end_word) begin
                            r_wr       <= 1'b1;
                            r_wr_addr  <= r_word_idx[ADDR_W-1:0];
                            r_wr_data  <= w_word;
                            r_word_idx <= r_word_idx + 1'b1;
                            r_byte_idx <= '0;
                            r_asm      <= '0;
                        end else begin
                            case (r_byte_idx)
                                2'd0:    r_asm[7:0]   <= s_data;
                                2'd1:    r_asm[15:8]  <= s_data;
                                default: r_asm[23:16] <= s_data;
                            endcase
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                        if (s_last) begin
`ifdef LOADER_CHKSUM_EN
                            r_state <= ST_CHK;
`else
                            r_state <= ST_DONE;
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef LOADER_CHKSUM_EN
                ST_CHK: begin
                    if (w_acc) begin
                        r_err_chk <= (s_data != r_sum);
                        r_state   <= ST_DONE;
                        r_ready   <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready        = r_ready;
    assign inst_sram_wr   = r_wr;
    assign inst_sram_addr = r_wr_addr;
    assign inst_sram_data = r_wr_data;
    assign cpu_hold       = r_hold;
    assign done           = r_done;
    assign word_count     = r_word_idx;
    assign err_ovf        = r_ovf;
`ifdef LOADER_CHKSUM_EN
    assign err_chk        = r_err_chk;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - scoreboard bench for inst_loader (default 8-bit and 2-bit address instances).
module tb_inst_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic        s_valid, s_last;
    logic [7:0]  s_data;

    logic        s_ready, wr, hold, done_a, ovf;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [8:0]  wc;

    logic        s_ready_b, wr_b, hold_b, done_b, ovf_b;
    logic [1:0]  addr_b;
    logic [31:0] data_b;
    logic [2:0]  wc_b;
`ifdef LOADER_CHKSUM_EN
    logic        err_chk, err_chk_b;
`endif

    int checks = 0;
    int errors = 0;
    logic [39:0] qa[$];
    logic [33:0] qb[$];

    always #5 clk = ~clk;

    inst_loader #(.ADDR_W(8), .DATA_W(32)) u_dut (
        .clk(clk), .rst(rst), .start(start_a), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .inst_sram_wr(wr), .inst_sram_addr(addr),
        .inst_sram_data(data), .cpu_hold(hold), .done(done_a), .word_count(wc),
`ifdef LOADER_CHKSUM_EN
        .err_chk(err_chk),
`endif
        .err_ovf(ovf)
    );

    inst_loader #(.ADDR_W(2), .DATA_W(32)) u_dut_small (
        .clk(clk), .rst(rst), .start(start_b), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready_b), .inst_sram_wr(wr_b), .inst_sram_addr(addr_b),
        .inst_sram_data(data_b), .cpu_hold(hold_b), .done(done_b), .word_count(wc_b),
`ifdef LOADER_CHKSUM_EN
        .err_chk(err_chk_b),
`endif
        .err_ovf(ovf_b)
    );

    always @(negedge clk) begin
        if (!rst && wr) begin
            logic [39:0] e;
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL wr_a unexpected got addr=%h data=%h want none", addr, data);
            end else begin
                e = qa.pop_front();
                if ({addr, data} !== e) begin
                    errors++;
                    $display("FAIL wr_a got addr=%h data=%h want addr=%h data=%h", addr, data, e[39:32], e[31:0]);
                end
            end
        end
        if (!rst && wr_b) begin
            logic [33:0] eb;
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL wr_b unexpected got addr=%h data=%h want none", addr_b, data_b);
            end else begin
                eb = qb.pop_front();
                if ({addr_b, data_b} !== eb) begin
                    errors++;
                    $display("FAIL wr_b got addr=%h data=%h want addr=%h data=%h", addr_b, data_b, eb[33:32], eb[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int sel);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input logic last);
        int n;
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        n = 0;
        while (!((sel == 0) ? s_ready : s_ready_b) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL ready_timeout got s_ready=0 want 1");
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    task automatic test_reset();
        expect_bit("rst_s_ready", s_ready, 1'b0);
        expect_bit("rst_wr", wr, 1'b0);
        expect_bit("rst_hold", hold, 1'b1);
        expect_bit("rst_done", done_a, 1'b0);
        expect_bit("rst_ovf", ovf, 1'b0);
        checks++;
        if ({addr, data, wc} !== '0) begin
            errors++;
            $display("FAIL rst_regs got addr=%h data=%h wc=%0d want 0", addr, data, wc);
        end
    endtask

    task automatic test_basic();
        logic [7:0] img [8] = '{8'h13, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h00, 8'h00, 8'hEA};
        qa.push_back({8'd0, 32'hE3A00013});
        qa.push_back({8'd1, 32'hEA000001});
        pulse_start(0);
        expect_bit("load_ready", s_ready, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(0, img[i], i == 7);
        expect_bit("basic_done", done_a, 1'b1);
        expect_bit("basic_hold_during_write", hold, 1'b1);
        expect_bit("basic_ready_off", s_ready, 1'b0);
        tick();
        expect_bit("basic_hold_released", hold, 1'b0);
        expect_bit("basic_ovf", ovf, 1'b0);
        checks++;
        if (wc !== 9'd2) begin
            errors++;
            $display("FAIL basic_wc got %0d want 2", wc);
        end
    endtask

    task automatic test_partial();
        qa.push_back({8'd0, 32'h00CCBBAA});
        pulse_start(0);
        expect_bit("restart_done_clear", done_a, 1'b0);
        expect_bit("restart_hold", hold, 1'b1);
        send_byte(0, 8'hAA, 1'b0);
        send_byte(0, 8'hBB, 1'b0);
        send_byte(0, 8'hCC, 1'b1);
        tick();
        expect_bit("partial_done", done_a, 1'b1);
        checks++;
        if (wc !== 9'd1) begin
            errors++;
            $display("FAIL partial_wc got %0d want 1", wc);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] img [8] = '{8'h13, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h00, 8'h00, 8'hEA};
        qa.push_back({8'd0, 32'hE3A00013});
        qa.push_back({8'd1, 32'hEA000001});
        pulse_start(0);
        for (int i = 0; i < 8; i++) begin
            send_byte(0, img[i], i == 7);
            if (i == 4) pulse_start(0);
            else if (i != 7) tick();
        end
        tick();
        expect_bit("gaps_done", done_a, 1'b1);
        checks++;
        if (wc !== 9'd2) begin
            errors++;
            $display("FAIL gaps_wc got %0d want 2", wc);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] img [6] = '{8'h13, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h00};
        qa.push_back({8'd0, 32'hE3A00013});
        pulse_start(0);
        for (int i = 0; i < 6; i++) send_byte(0, img[i], 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        expect_bit("rstmid_ready", s_ready, 1'b0);
        expect_bit("rstmid_hold", hold, 1'b1);
        expect_bit("rstmid_done", done_a, 1'b0);
        checks++;
        if (wc !== 9'd0) begin
            errors++;
            $display("FAIL rstmid_wc got %0d want 0", wc);
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 4; k++)
            qb.push_back({2'(k), 8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)});
        pulse_start(1);
        for (int i = 0; i < 20; i++) begin
            send_byte(1, 8'(i + 1), i == 19);
            if (i == 15) expect_bit("ovf_not_yet", ovf_b, 1'b0);
        end
        tick();
        expect_bit("ovf_set", ovf_b, 1'b1);
        expect_bit("ovf_done", done_b, 1'b1);
        expect_bit("ovf_ready_off", s_ready_b, 1'b0);
        checks++;
        if (wc_b !== 3'd4) begin
            errors++;
            $display("FAIL ovf_wc got %0d want 4", wc_b);
        end
        pulse_start(1);
        expect_bit("ovf_cleared_by_start", ovf_b, 1'b0);
    endtask

`ifdef LOADER_CHKSUM_EN
    task automatic test_chksum(input logic [7:0] trailer, input logic want_err);
        qa.push_back({8'd0, 32'h04030201});
        pulse_start(0);
        for (int i = 0; i < 4; i++) send_byte(0, 8'(i + 1), i == 3);
        expect_bit("chk_not_done", done_a, 1'b0);
        send_byte(0, trailer, 1'b1);
        expect_bit("chk_done", done_a, 1'b1);
        expect_bit("chk_err", err_chk, want_err);
    endtask
`endif

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_partial();
        test_gaps();
        test_reset_mid();
        test_overflow();
`ifdef LOADER_CHKSUM_EN
        test_chksum(8'h0A, 1'b0);
        test_chksum(8'h0B, 1'b1);
`endif
        repeat (3) tick();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got pending a=%0d b=%0d want 0", qa.size(), qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
